// File: rtl/judge_pkg.sv
// Shared types and constants for the LED round judge.
// JUDGE_DEBOUNCE_EN (optional) enables the button debouncer in btn_sync.
package judge_pkg;

  localparam int NUM_BTN        = 4;
  localparam int DEBOUNCE_TICKS = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HIT,
    LOCKOUT
  } state_t;

endpackage

// File: rtl/btn_sync.sv
// Per-button synchronizer, optional debouncer and rising-edge detector.
// JUDGE_DEBOUNCE_EN: require DEBOUNCE_TICKS stable slowen ticks before a press.
module btn_sync
  import judge_pkg::*;
#(
  parameter int W = NUM_BTN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         slowen,
  input  logic [W-1:0] btn,
  output logic [W-1:0] press
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] lvl;
  logic [W-1:0] prev;
  logic [W-1:0] armed;
  logic [1:0]   vld;

`ifdef JUDGE_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [CW-1:0] cnt [W];
  logic [W-1:0]  deb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < W; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!sync2[i]) begin
          cnt[i] <= '0;
          deb[i] <= 1'b0;
        end else if (slowen && cnt[i] != CW'(DEBOUNCE_TICKS)) begin
          cnt[i] <= cnt[i] + CW'(1);
          if (cnt[i] == CW'(DEBOUNCE_TICKS - 1)) deb[i] <= 1'b1;
        end
      end
    end
  end

  assign lvl = deb;
`else
  logic unused_slowen;

  assign unused_slowen = slowen;
  assign lvl           = sync2;
`endif

  // A bit only arms once it has been seen low after reset,
  // so a button held through reset release never yields an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      armed <= '0;
      vld   <= '0;
      press <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      vld   <= {vld[0], 1'b1};
      prev  <= lvl;
      armed <= armed | ({W{vld[1]}} & ~sync2);
      press <= lvl & ~prev & armed;
    end
  end

endmodule

// File: rtl/led_round_judge.sv
// Reaction-round judge: lights the target LED, scores hits, locks out false starts.
// JUDGE_DEBOUNCE_EN (optional) adds a button debouncer inside btn_sync.
module led_round_judge
  import judge_pkg::*;
#(
  parameter int LOCKOUT_TICKS = 8,
  parameter int SCORE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slowen,
  input  logic               leds_on,
  input  logic               clear,
  input  logic [1:0]         led_control,
  input  logic [3:0]         btn,
  output logic               winrnd,
  output logic [3:0]         led,
  output logic [SCORE_W-1:0] score
);

  localparam int LW = $clog2(LOCKOUT_TICKS + 1);

  state_t               state;
  state_t               state_nxt;
  logic [NUM_BTN-1:0]   press;
  logic [NUM_BTN-1:0]   target;
  logic [LW-1:0]        lock_cnt;
  logic                 win_nxt;
  logic                 ld_cnt;

  btn_sync #(
    .W (NUM_BTN)
  ) u_btn_sync (
    .clk    (clk),
    .rst    (rst),
    .slowen (slowen),
    .btn    (btn),
    .press  (press)
  );

  assign target = NUM_BTN'(1) << led_control;

  always_comb begin
    state_nxt = state;
    win_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|press)       state_nxt = LOCKOUT;
        else if (leds_on) state_nxt = ARMED;
      end
      ARMED: begin
        if (press == target) begin
          state_nxt = HIT;
          win_nxt   = 1'b1;
        end else if (|press) begin
          state_nxt = LOCKOUT;
        end else if (!leds_on) begin
          state_nxt = IDLE;
        end
      end
      HIT: begin
        if (!leds_on) state_nxt = IDLE;
      end
      LOCKOUT: begin
        if (lock_cnt == '0 && !leds_on) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over everything, including a correct press.
    if (clear) begin
      state_nxt = IDLE;
      win_nxt   = 1'b0;
    end
  end

  assign ld_cnt = (state != LOCKOUT) && (state_nxt == LOCKOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      winrnd <= 1'b0;
      led    <= '0;
    end else begin
      state  <= state_nxt;
      winrnd <= win_nxt;
      led    <= (leds_on && !clear) ? target : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (clear) begin
      lock_cnt <= '0;
    end else if (ld_cnt) begin
      lock_cnt <= LW'(LOCKOUT_TICKS);
    end else if (state == LOCKOUT && slowen && lock_cnt != '0) begin
      lock_cnt <= lock_cnt - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score <= '0;
    end else if (winrnd && score != {SCORE_W{1'b1}}) begin
      score <= score + SCORE_W'(1);
    end
  end

endmodule

// File: doc/led_round_judge.md
LED_ROUND_JUDGE -- requirements
Module: led_round_judge

Interface
REQ-001 Parameter LOCKOUT_TICKS, default 8, number of slowen pulses a false start blocks the player.
REQ-002 Parameter SCORE_W, default 4, width of the saturating hit counter.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 slowen  input  1  one-cycle tick from the divide-by-256 enable generator.
REQ-006 leds_on  input  1  round controller says target LED is lit.
REQ-007 clear  input  1  round controller abort/clear strobe.
REQ-008 led_control  input  2  index of target LED.
REQ-009 btn  input  4  raw asynchronous player buttons, bit i pairs with LED i.
REQ-010 winrnd  output  1  one-cycle pulse back to the round controller on a correct hit.
REQ-011 led  output  4  physical LED drive.
REQ-012 score  output  SCORE_W  count of correct hits.

Function
REQ-013 Every btn bit SHALL pass a 2-flop synchronizer followed by a registered rising-edge detector. A press is therefore visible to the FSM 3 clk edges after the edge that first samples it.
REQ-014 led SHALL equal the one-hot decode of led_control, registered, while leds_on=1 and clear=0. Otherwise led SHALL be 4'b0000.
REQ-015 FSM states: IDLE, ARMED, HIT, LOCKOUT.
REQ-016 IDLE -> ARMED when leds_on=1 and clear=0.
REQ-017 IDLE -> LOCKOUT on any press (false start).
REQ-018 ARMED -> HIT when the only press in that cycle is btn[led_control]. winrnd SHALL be 1 for exactly the next cycle.
REQ-019 ARMED -> LOCKOUT on a press of any other button, or on simultaneous presses including the target. winrnd stays 0.
REQ-020 ARMED -> IDLE when leds_on falls with no press (miss). No pulse is produced.
REQ-021 HIT -> IDLE once leds_on=0. Further presses in HIT are ignored.
REQ-022 LOCKOUT SHALL load a counter with LOCKOUT_TICKS and decrement it on each slowen. The FSM returns to IDLE when the counter reaches 0 and leds_on=0. Presses in LOCKOUT are ignored and do not reload the counter.
REQ-023 clear=1 in any state SHALL force IDLE and drive led to 0 on the next edge. score is not affected.
REQ-024 clear takes priority over a simultaneous correct press: no winrnd.
REQ-025 score SHALL increment by 1 on each winrnd and saturate at 2^SCORE_W-1, with no wrap.
REQ-026 winrnd SHALL never assert on two consecutive cycles.

Reset
REQ-027 While rst=1, asynchronously: state=IDLE, winrnd=0, led=0, score=0, lockout counter=0, synchronizer and edge registers=0.
REQ-028 A press held across reset release SHALL NOT produce an edge.
REQ-029 Reset asserted mid-round SHALL abandon the round with no pulse.

Configuration
REQ-030 Macro JUDGE_DEBOUNCE_EN defined: a synchronized button counts as pressed only after it is stable high for 4 consecutive slowen ticks. This adds up to 4x256 cycles of latency. The edge detector acts on the debounced level.
REQ-031 Macro JUDGE_DEBOUNCE_EN undefined: the debouncer is absent and the latency is exactly as in REQ-013.

Structure
REQ-032 Shared package judge_pkg SHALL hold the state enumeration, NUM_BTN=4, and DEBOUNCE_TICKS=4.
REQ-033 One sub-module, btn_sync, SHALL contain the per-bit synchronizer, the optional debouncer and the edge detector. It is instantiated once, 4 bits wide.

Verification
REQ-034 rst pulse, then idle 10 cycles -> led=0, winrnd=0, score=0.
REQ-035 leds_on=1 with led_control=2'b10 -> led=4'b0100. A btn[2] pulse 5 cycles wide -> winrnd high exactly 1 cycle, 4 edges after the press is first sampled; score=1.
REQ-036 led_control=2'b01, press btn[3] -> no winrnd, state LOCKOUT. A btn[1] press afterwards is ignored until 8 slowen ticks have elapsed and leds_on=0.
REQ-037 Press btn[0] while leds_on=0 -> LOCKOUT. Assert clear=1 for 1 cycle -> IDLE and led=0 on the next edge.
REQ-038 Force 20 correct hits with SCORE_W=4 -> score holds at 15.
REQ-039 Press btn[1] and btn[2] together with target 1 -> no winrnd, LOCKOUT. Repeat with JUDGE_DEBOUNCE_EN and a 2-tick glitch on the target -> no winrnd.
